// File: rtl/azadi_pinmux.sv
// azadi_pinmux: runtime pad multiplexer; every function change tristates the pad for a guard interval.
// Optional feature: define PINMUX_INPUT_SYNC_EN to pass io_in through a 2-flop synchroniser.
module azadi_pinmux #(
   parameter int NPADS  = 38,
   parameter int NFUNC  = 4,
   parameter int SETTLE = 2,
   localparam int SW    = $clog2(NFUNC)
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [6:0]             cfg_addr,
   input  logic [SW-1:0]          cfg_wdata,
   output logic                   cfg_err,
   output logic                   cfg_locked,
   input  logic [NPADS*NFUNC-1:0] fn_out,
   input  logic [NPADS*NFUNC-1:0] fn_oe,
   output logic [NPADS*NFUNC-1:0] fn_in,
   input  logic [NPADS-1:0]       io_in,
   output logic [NPADS-1:0]       io_out,
   output logic [NPADS-1:0]       io_oeb,
   output logic [1:0]             dbg_state
);
   localparam int AW = $clog2(NPADS);
   localparam logic [6:0] LOCK_ADDR = 7'(NPADS);

   typedef enum logic [1:0] {IDLE = 2'd0, GUARD = 2'd1, APPLY = 2'd2} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] tgt_addr_q, tgt_addr_d;
   logic [SW-1:0] tgt_data_q, tgt_data_d;
   logic          locked_q, locked_d;
   logic          err_q, err_d;
   logic          sel_we;
   logic          guard;
   logic [SW-1:0] sel [NPADS];
   logic [SW-1:0] cur_sel;
   logic [NPADS-1:0] out_d, oeb_d, pad_in;

   // Handshake: a write transfers on any rising edge where cfg_valid & cfg_ready; ready is high only in IDLE.
   assign cfg_ready  = (state_q == IDLE);
   assign cfg_err    = err_q;
   assign cfg_locked = locked_q;
   assign dbg_state  = state_q;
   assign guard      = (state_q != IDLE);
   assign cur_sel    = sel[cfg_addr[AW-1:0]];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tgt_addr_d = tgt_addr_q;
      tgt_data_d = tgt_data_q;
      locked_d   = locked_q;
      err_d      = 1'b0;
      sel_we     = 1'b0;
      case (state_q)
         IDLE: begin
            if (cfg_valid) begin
               if (locked_q || (cfg_addr > LOCK_ADDR)) begin
                  err_d = 1'b1;
               end else if (cfg_addr == LOCK_ADDR) begin
                  if (cfg_wdata[0]) locked_d = 1'b1;
               end else if (cfg_wdata != cur_sel) begin
                  tgt_addr_d = cfg_addr[AW-1:0];
                  tgt_data_d = cfg_wdata;
                  cnt_d      = 4'd0;
                  state_d    = GUARD;
               end
            end
         end
         GUARD: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(SETTLE - 1)) state_d = APPLY;
         end
         APPLY: begin
            sel_we  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         tgt_addr_q <= '0;
         tgt_data_q <= '0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tgt_addr_q <= tgt_addr_d;
         tgt_data_q <= tgt_data_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int p = 0; p < NPADS; p++) sel[p] <= '0;
      end else if (sel_we) begin
         sel[tgt_addr_q] <= tgt_data_q;
      end
   end

   // The guard target stays tristated through APPLY so the old and new drivers never overlap.
   always_comb begin
      out_d = '0;
      oeb_d = '1;
      for (int p = 0; p < NPADS; p++) begin
         out_d[p] = fn_out[p*NFUNC + int'(sel[p])];
         oeb_d[p] = ~fn_oe[p*NFUNC + int'(sel[p])];
         if (guard && (tgt_addr_q == AW'(p))) begin
            out_d[p] = 1'b0;
            oeb_d[p] = 1'b1;
         end
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         io_out <= '0;
         io_oeb <= '1;
      end else begin
         io_out <= out_d;
         io_oeb <= oeb_d;
      end
   end

`ifdef PINMUX_INPUT_SYNC_EN
   logic [NPADS-1:0] sync1_q, sync2_q;
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= io_in;
         sync2_q <= sync1_q;
      end
   end
   assign pad_in = sync2_q;
`else
   assign pad_in = io_in;
`endif

   always_comb begin
      fn_in = '0;
      for (int p = 0; p < NPADS; p++) begin
         for (int f = 0; f < NFUNC; f++) begin
            if (sel[p] == SW'(f)) fn_in[p*NFUNC + f] = pad_in[p];
         end
      end
   end
endmodule
